// File: rtl/ca_row_reader.sv
// ca_row_reader: consumer end of the Rule 110 engine row stream.
// Captures one WIDTH-bit generation through a valid/ready handshake into a
// shadow register and hands it to the host one byte at a time. Each rising
// edge of the slow, unsynchronised rd_req pin advances to the next byte.
module ca_row_reader #(
  parameter int WIDTH = 32,
  parameter int IDXW  = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             row_valid,
  input  logic [WIDTH-1:0] row_data,
  output logic             row_ready,
  input  logic             rd_req,
  output logic [7:0]       byte_out,
  output logic             byte_valid,
  output logic [IDXW-1:0]  byte_index,
  output logic             row_done,
  output logic             row_skipped,
  output logic [7:0]       rows_read
);

  localparam int              NBYTES = WIDTH / 8;
  localparam logic [IDXW-1:0] LAST   = IDXW'(NBYTES - 1);

  typedef enum logic {IDLE, SEND} state_t;

  state_t                       state_q;
  logic [NBYTES-1:0][7:0]       shadow_q;
  logic [IDXW-1:0]              idx_q;
  logic                         done_q;
  logic                         skipped_q;
  logic                         miss_q;
  logic [7:0]                   rows_q;
  logic                         s1_q, s2_q, s3_q;
  logic                         step;
  logic [7:0]                   byte_sel;

  // rd_req synchroniser plus history flop for rising-edge detection
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= rd_req;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  assign step = s2_q & ~s3_q;

  // Capture / send FSM; row_done is a registered one-cycle pulse
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      shadow_q  <= '0;
      idx_q     <= '0;
      done_q    <= 1'b0;
      skipped_q <= 1'b0;
      miss_q    <= 1'b0;
      rows_q    <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          // A step arriving here has no row to advance and is dropped.
          if (row_valid) begin
            shadow_q  <= row_data;
            idx_q     <= '0;
            skipped_q <= miss_q;
            miss_q    <= 1'b0;
            state_q   <= SEND;
          end
        end
        SEND: begin
          // Any offer we cannot take while sending is a lost generation.
          if (row_valid) miss_q <= 1'b1;
          if (step) begin
            if (idx_q == LAST) begin
              done_q  <= 1'b1;
              rows_q  <= rows_q + 8'd1;
              idx_q   <= '0;
              state_q <= IDLE;
            end else begin
              idx_q <= idx_q + 1'b1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Byte select from the shadow register, little-endian by byte index
  always_comb begin
    byte_sel = 8'h00;
    for (int i = 0; i < NBYTES; i++) begin
      if (idx_q == IDXW'(i)) byte_sel = shadow_q[i];
    end
  end

  assign row_ready   = (state_q == IDLE);
  assign byte_valid  = (state_q == SEND);
  assign byte_out    = (state_q == SEND) ? byte_sel : 8'h00;
  assign byte_index  = idx_q;
  assign row_done    = done_q;
  assign row_skipped = skipped_q;
  assign rows_read   = rows_q;

endmodule

// File: tb/tb_ca_row_reader.sv
// Directed bench for ca_row_reader (WIDTH=32): table of rows with
// hand-listed byte sequences, plus sequences for step latency, skip
// detection, input isolation, reset mid-row and rows_read wrap.
module tb_ca_row_reader;

  logic        clk = 1'b0;
  logic        reset;
  logic        row_valid;
  logic [31:0] row_drv;
  logic [31:0] row_rnd;
  logic        scramble;
  logic [31:0] row_data;
  logic        row_ready;
  logic        rd_req;
  logic [7:0]  byte_out;
  logic        byte_valid;
  logic [7:0]  byte_index;
  logic        row_done;
  logic        row_skipped;
  logic [7:0]  rows_read;

  int n_cmp  = 0;
  int n_fail = 0;
  int done_cnt = 0;

  assign row_data = scramble ? row_rnd : row_drv;

  ca_row_reader #(.WIDTH(32), .IDXW(8)) dut (
    .clk(clk), .reset(reset),
    .row_valid(row_valid), .row_data(row_data), .row_ready(row_ready),
    .rd_req(rd_req),
    .byte_out(byte_out), .byte_valid(byte_valid), .byte_index(byte_index),
    .row_done(row_done), .row_skipped(row_skipped), .rows_read(rows_read)
  );

  always #5 clk = ~clk;

  // Count row_done pulses away from the active edge
  always @(negedge clk) if (!reset && row_done) done_cnt++;

  // Garbage on row_data every cycle while scrambling
  initial begin
    row_rnd = 32'h0;
    forever begin
      @(posedge clk);
      #2 row_rnd = $urandom;
    end
  end

  typedef struct packed {
    logic [31:0]      data;
    logic [3:0][7:0]  exp;   // exp[k] = byte k
  } vec_t;

  vec_t vecs [6];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Offer a row and hold it until the handshake edge (bounded)
  task automatic capture(input logic [31:0] d);
    int n;
    row_drv   = d;
    row_valid = 1'b1;
    n = 0;
    while (!row_ready && n < 20) begin
      tick();
      n++;
    end
    if (!row_ready) begin
      n_cmp++;
      n_fail++;
      $display("FAIL capture_timeout: row_ready stuck at %0b expected 1", row_ready);
    end
    tick();
    row_valid = 1'b0;
  endtask

  // One rd_req pulse: 3 high / 3 low; samples outputs at edge t+2
  task automatic pulse(output logic done_o, output logic rdy_o);
    rd_req = 1'b1;
    tick(); tick(); tick();
    done_o = row_done;
    rdy_o  = row_ready;
    rd_req = 1'b0;
    tick(); tick(); tick();
  endtask

  task automatic read_out(input vec_t v, input string tag);
    logic d, r;
    check({tag, "_b0"}, byte_out, v.exp[0]);
    check({tag, "_i0"}, byte_index, 0);
    for (int k = 1; k < 4; k++) begin
      pulse(d, r);
      check({tag, "_b"}, byte_out, v.exp[k]);
      check({tag, "_i"}, byte_index, k);
    end
    pulse(d, r);
    check({tag, "_done"}, d, 1);
    check({tag, "_rdy"}, r, 1);
  endtask

  initial begin
    logic d, r;
    int dc;
    logic [7:0] rr;

    vecs[0] = '{data: 32'hDEADBEEF, exp: {8'hDE, 8'hAD, 8'hBE, 8'hEF}};
    vecs[1] = '{data: 32'h12345678, exp: {8'h12, 8'h34, 8'h56, 8'h78}};
    vecs[2] = '{data: 32'h00000000, exp: {8'h00, 8'h00, 8'h00, 8'h00}};
    vecs[3] = '{data: 32'hFFFFFFFF, exp: {8'hFF, 8'hFF, 8'hFF, 8'hFF}};
    vecs[4] = '{data: 32'h80000001, exp: {8'h80, 8'h00, 8'h00, 8'h01}};
    vecs[5] = '{data: 32'hA5C30F96, exp: {8'hA5, 8'hC3, 8'h0F, 8'h96}};

    reset = 1'b1; row_valid = 1'b0; row_drv = 32'h0; scramble = 1'b0; rd_req = 1'b0;

    // Reset defaults
    repeat (3) tick();
    reset = 1'b0;
    for (int c = 0; c < 5; c++) begin
      tick();
      check("rst_ready", row_ready, 1);
      check("rst_bvalid", byte_valid, 0);
      check("rst_byte", byte_out, 0);
      check("rst_idx", byte_index, 0);
      check("rst_rows", rows_read, 0);
      check("rst_skip", row_skipped, 0);
    end
    check("rst_nodone", done_cnt, 0);

    // DEADBEEF with explicit step latency on the first step
    capture(32'hDEADBEEF);
    check("db_ready0", row_ready, 0);
    check("db_bvalid", byte_valid, 1);
    check("db_b0", byte_out, 8'hEF);
    check("db_i0", byte_index, 0);
    rd_req = 1'b1;
    tick();                      // edge t
    check("lat_t", byte_out, 8'hEF);
    tick();                      // edge t+1
    check("lat_t1", byte_out, 8'hEF);
    check("lat_t1i", byte_index, 0);
    tick();                      // edge t+2
    check("lat_t2", byte_out, 8'hBE);
    check("lat_t2i", byte_index, 1);
    tick();
    rd_req = 1'b0;
    repeat (3) tick();
    pulse(d, r);
    check("db_b2", byte_out, 8'hAD);
    pulse(d, r);
    check("db_b3", byte_out, 8'hDE);
    dc = done_cnt;
    rd_req = 1'b1;
    tick(); tick();
    check("db_predone", row_done, 0);
    tick();
    check("db_done", row_done, 1);
    check("db_done_rdy", row_ready, 1);
    check("db_rows", rows_read, 1);
    tick();
    check("db_done_off", row_done, 0);
    rd_req = 1'b0;
    repeat (3) tick();
    check("db_one_pulse", done_cnt - dc, 1);

    // Table-driven rows
    for (int i = 0; i < 6; i++) begin
      capture(vecs[i].data);
      read_out(vecs[i], "tbl");
      check("tbl_rows", rows_read, i + 2);
    end

    // Skip detection
    capture(32'hAAAA0001);
    check("skA", row_skipped, 0);
    row_drv = 32'hBBBB0002; row_valid = 1'b1;
    repeat (3) tick();
    row_valid = 1'b0;
    check("skA_busy", row_ready, 0);
    for (int k = 0; k < 4; k++) pulse(d, r);
    check("skA_done", row_ready, 1);
    capture(32'hCCCC0003);
    check("skC", row_skipped, 1);
    check("skC_b0", byte_out, 8'h03);
    for (int k = 0; k < 4; k++) pulse(d, r);
    check("skC_hold", row_skipped, 1);
    capture(32'hDDDD0004);
    check("skD", row_skipped, 0);
    for (int k = 0; k < 4; k++) pulse(d, r);

    // Input isolation
    capture(32'h13579BDF);
    scramble = 1'b1;
    check("iso_b0", byte_out, 8'hDF);
    pulse(d, r); check("iso_b1", byte_out, 8'h9B);
    pulse(d, r); check("iso_b2", byte_out, 8'h57);
    pulse(d, r); check("iso_b3", byte_out, 8'h13);
    pulse(d, r); check("iso_done", d, 1);
    scramble = 1'b0;

    // Reset mid-row with rd_req held high through reset
    capture(32'h11223344);
    pulse(d, r);
    check("mr_b1", byte_out, 8'h33);
    dc = done_cnt;
    rd_req = 1'b1;
    reset  = 1'b1;
    tick(); tick();
    reset = 1'b0;
    tick();
    check("mr_ready", row_ready, 1);
    check("mr_idx", byte_index, 0);
    check("mr_rows", rows_read, 0);
    check("mr_bvalid", byte_valid, 0);
    repeat (4) tick();
    check("mr_nodone", done_cnt - dc, 0);
    capture(32'h55667788);
    check("mr_cap_b0", byte_out, 8'h88);
    repeat (6) tick();
    check("mr_hold_b0", byte_out, 8'h88);
    check("mr_hold_i0", byte_index, 0);
    rd_req = 1'b0;
    repeat (3) tick();
    pulse(d, r);
    check("mr_b1b", byte_out, 8'h77);
    for (int k = 0; k < 3; k++) pulse(d, r);
    check("mr_rows1", rows_read, 1);

    // Wrap: 256 rows from a fresh reset
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    tick();
    dc = done_cnt;
    for (int n = 0; n < 256; n++) begin
      capture(32'h01020304 + n);
      for (int k = 0; k < 4; k++) pulse(d, r);
      if (n == 254) begin
        rr = rows_read;
        check("wrap_255", rr, 255);
      end
    end
    check("wrap_rows", rows_read, 0);
    check("wrap_dones", done_cnt - dc, 256);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  // Global time limit
  initial begin
    #2000000;
    $display("FAIL timeout: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
